// File: rtl/fv_axi_mem_initiator.sv
// AXI4 bus types shared with the FV memory model, plus a single-outstanding
// command/stream to AXI4 initiator used for image preload, readback and directed traffic.
package ariane_axi;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned UserWidth = 1;

    typedef logic [IdWidth-1:0]   id_t;
    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [StrbWidth-1:0] strb_t;
    typedef logic [UserWidth-1:0] user_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        user_t      user;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
    } ar_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module fv_axi_mem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [63:0]       cmd_addr_i,
    input  logic [7:0]        cmd_len_i,
    input  logic              wdata_valid_i,
    output logic              wdata_ready_o,
    input  logic [63:0]       wdata_i,
    input  logic [7:0]        wstrb_i,
    output logic              rdata_valid_o,
    input  logic              rdata_ready_i,
    output logic [63:0]       rdata_o,
    output logic              rdata_last_o,
    output logic              done_o,
    output logic              err_o,
    output ariane_axi::req_t  axi_req_o,
    input  ariane_axi::resp_t axi_resp_i
);
    // IDLE: accept command | CHECK: alignment / 4 KB test | AW, AR: address phase
    // W: write beats | B: write response | R: read beats | DONE: completion pulse
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    localparam ariane_axi::id_t ID       = ariane_axi::id_t'(AXI_ID);
    localparam logic [31:0]     TMO_LAST = TIMEOUT_CYCLES - 1;
    localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_write;
    logic [63:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic        r_err;
    logic [31:0] r_tmo;

    logic        w_last_beat;
    logic [12:0] w_span;
    logic        w_chk_err;
    logic        w_hs;
    logic        w_waiting;
    logic        w_tmo_hit;
    logic        w_err_set;

    assign w_last_beat = (r_cnt == r_len);
    assign w_span      = {1'b0, r_addr[11:0]} + (({5'd0, r_len} + 13'd1) << 3);
    assign w_chk_err   = (r_addr[2:0] != 3'd0) || (w_span > 13'd4096);
    assign w_waiting   = (r_state == S_AW) || (r_state == S_W) || (r_state == S_B) ||
                         (r_state == S_AR) || (r_state == S_R);
    assign w_tmo_hit   = TMO_EN && w_waiting && !w_hs && (r_tmo == TMO_LAST);

    always_comb begin
        w_hs = 1'b0;
        case (r_state)
            S_AW:    w_hs = axi_resp_i.aw_ready;
            S_W:     w_hs = wdata_valid_i && axi_resp_i.w_ready;
            S_B:     w_hs = axi_resp_i.b_valid;
            S_AR:    w_hs = axi_resp_i.ar_ready;
            S_R:     w_hs = axi_resp_i.r_valid && rdata_ready_i;
            default: w_hs = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_err_set     = 1'b0;
        axi_req_o     = '0;
        cmd_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        rdata_valid_o = 1'b0;
        rdata_o       = axi_resp_i.r.data;
        rdata_last_o  = 1'b0;
        done_o        = 1'b0;
        err_o         = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (w_chk_err) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = r_write ? S_AW : S_AR;
                end
            end
            S_AW: begin
                axi_req_o.aw_valid    = 1'b1;
                axi_req_o.aw.id       = ID;
                axi_req_o.aw.addr     = r_addr;
                axi_req_o.aw.len      = r_len;
                axi_req_o.aw.size     = 3'd3;
                axi_req_o.aw.burst    = 2'b01;
                if (w_hs) w_state_nxt = S_W;
            end
            S_W: begin
                axi_req_o.w_valid     = wdata_valid_i;
                axi_req_o.w.data      = wdata_i;
                axi_req_o.w.strb      = wstrb_i;
                axi_req_o.w.last      = w_last_beat;
                wdata_ready_o         = axi_resp_i.w_ready;
                if (w_hs && w_last_beat) w_state_nxt = S_B;
            end
            S_B: begin
                axi_req_o.b_ready = 1'b1;
                if (w_hs) begin
                    w_err_set   = (axi_resp_i.b.resp != 2'b00) || (axi_resp_i.b.id != ID);
                    w_state_nxt = S_DONE;
                end
            end
            S_AR: begin
                axi_req_o.ar_valid    = 1'b1;
                axi_req_o.ar.id       = ID;
                axi_req_o.ar.addr     = r_addr;
                axi_req_o.ar.len      = r_len;
                axi_req_o.ar.size     = 3'd3;
                axi_req_o.ar.burst    = 2'b01;
                if (w_hs) w_state_nxt = S_R;
            end
            S_R: begin
                axi_req_o.r_ready = rdata_ready_i;
                rdata_valid_o     = axi_resp_i.r_valid;
                rdata_last_o      = axi_resp_i.r.last;
                if (w_hs) begin
                    // an early or missing rlast is flagged but the burst still ends on rlast
                    w_err_set = (axi_resp_i.r.resp != 2'b00) || (axi_resp_i.r.id != ID) ||
                                (axi_resp_i.r.last != w_last_beat);
                    if (axi_resp_i.r.last) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_o      = 1'b1;
                err_o       = r_err;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_tmo_hit) begin
            w_state_nxt = S_DONE;
            w_err_set   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && cmd_valid_i) begin
                r_write <= cmd_write_i;
                r_addr  <= cmd_addr_i;
                r_len   <= cmd_len_i;
            end
            if (r_state == S_CHECK) begin
                r_cnt <= '0;
            end else if (w_hs && (r_state == S_W || (r_state == S_R && !w_last_beat))) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == S_DONE) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_waiting && !w_hs && w_state_nxt == r_state) begin
                r_tmo <= r_tmo + 32'd1;
            end else begin
                r_tmo <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fv_axi_mem_initiator.sv
// Bench for fv_axi_mem_initiator: behavioural AXI memory responder, byte-level
// reference memory, directed cases and a randomized command stream.
module tb_fv_axi_mem_initiator;
    localparam int unsigned TMO = 16;
    localparam int unsigned AID = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [63:0]       cmd_addr_i;
    logic [7:0]        cmd_len_i;
    logic              wdata_valid_i, wdata_ready_o;
    logic [63:0]       wdata_i;
    logic [7:0]        wstrb_i;
    logic              rdata_valid_o, rdata_ready_i, rdata_last_o;
    logic [63:0]       rdata_o;
    logic              done_o, err_o;
    ariane_axi::req_t  axi_req;
    ariane_axi::resp_t axi_resp;

    int n_cmp = 0;
    int n_mis = 0;

    fv_axi_mem_initiator #(.TIMEOUT_CYCLES(TMO), .AXI_ID(AID)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i),
        .rdata_o(rdata_o), .rdata_last_o(rdata_last_o),
        .done_o(done_o), .err_o(err_o),
        .axi_req_o(axi_req), .axi_resp_i(axi_resp)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    // reference memory, one 64-bit word per aligned address
    logic [63:0] ref_mem [logic [63:0]];
    logic [63:0] mem_slv [logic [63:0]];
    logic [63:0] wbuf [257];
    logic [7:0]  sbuf [257];
    logic [63:0] rbuf [$];
    bit          rlq  [$];

    function automatic logic [63:0] ref_rd(input logic [63:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : 64'd0;
    endfunction

    task automatic ref_wr(input logic [63:0] addr, input int len);
        logic [63:0] wa, w;
        for (int i = 0; i <= len; i++) begin
            wa = (addr >> 3) + 64'(i);
            w  = ref_rd(wa);
            for (int b = 0; b < 8; b++)
                if (sbuf[i][b]) w[8*b +: 8] = wbuf[i][8*b +: 8];
            ref_mem[wa] = w;
        end
    endtask

    // handshakes seen at each rising edge, consumed by the responder on the falling edge
    bit                   hs_aw, hs_w, hs_b, hs_ar, hs_r;
    ariane_axi::aw_chan_t cap_aw;
    ariane_axi::ar_chan_t cap_ar;
    ariane_axi::w_chan_t  cap_w;
    int                   vld_seen = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_aw <= 1'b0; hs_w <= 1'b0; hs_b <= 1'b0; hs_ar <= 1'b0; hs_r <= 1'b0;
        end else begin
            hs_aw  <= axi_req.aw_valid && axi_resp.aw_ready;
            hs_w   <= axi_req.w_valid && axi_resp.w_ready;
            hs_b   <= axi_req.b_ready && axi_resp.b_valid;
            hs_ar  <= axi_req.ar_valid && axi_resp.ar_ready;
            hs_r   <= axi_req.r_ready && axi_resp.r_valid;
            cap_aw <= axi_req.aw;
            cap_ar <= axi_req.ar;
            cap_w  <= axi_req.w;
            if (axi_req.aw_valid || axi_req.ar_valid) vld_seen <= vld_seen + 1;
        end
    end

    bit          slv_rand = 1'b0;
    bit          aw_block = 1'b0;
    logic [63:0] exp_addr;
    logic [7:0]  exp_len;

    initial begin : responder
        logic [63:0] wr_addr, rd_addr, wa, w;
        int  wr_len, rd_len, wr_beat, rd_beat;
        bit  wr_act, rd_act, b_pend, r_vld;
        wr_addr = '0; rd_addr = '0; wr_len = 0; rd_len = 0; wr_beat = 0; rd_beat = 0;
        wr_act = 0; rd_act = 0; b_pend = 0; r_vld = 0;
        axi_resp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wr_act = 0; rd_act = 0; b_pend = 0; r_vld = 0;
                axi_resp = '0;
            end else begin
                if (hs_aw) begin
                    chk("aw_addr", cap_aw.addr, exp_addr);
                    chk("aw_len", 64'(cap_aw.len), 64'(exp_len));
                    chk("aw_fmt", 64'({cap_aw.size, cap_aw.burst, cap_aw.id, cap_aw.cache, cap_aw.prot}),
                        64'({3'd3, 2'd1, 4'(AID), 4'd0, 3'd0}));
                    wr_addr = cap_aw.addr; wr_len = int'(cap_aw.len); wr_beat = 0; wr_act = 1;
                end
                if (hs_w) begin
                    chk("w_after_aw", 64'(wr_act), 64'd1);
                    chk("wlast", 64'(cap_w.last), 64'(wr_beat == wr_len));
                    wa = (wr_addr >> 3) + 64'(wr_beat);
                    w  = mem_slv.exists(wa) ? mem_slv[wa] : 64'd0;
                    for (int b = 0; b < 8; b++)
                        if (cap_w.strb[b]) w[8*b +: 8] = cap_w.data[8*b +: 8];
                    mem_slv[wa] = w;
                    if (wr_beat == wr_len) begin b_pend = 1; wr_act = 0; end
                    wr_beat++;
                end
                if (hs_b) b_pend = 0;
                if (hs_ar) begin
                    chk("ar_addr", cap_ar.addr, exp_addr);
                    chk("ar_len", 64'(cap_ar.len), 64'(exp_len));
                    chk("ar_fmt", 64'({cap_ar.size, cap_ar.burst, cap_ar.id}), 64'({3'd3, 2'd1, 4'(AID)}));
                    rd_addr = cap_ar.addr; rd_len = int'(cap_ar.len); rd_beat = 0; rd_act = 1;
                end
                if (hs_r) begin
                    r_vld = 0;
                    rd_beat++;
                    if (rd_beat > rd_len) rd_act = 0;
                end
                axi_resp.aw_ready = !aw_block && (!slv_rand || $urandom_range(0, 3) != 0);
                axi_resp.w_ready  = !slv_rand || $urandom_range(0, 3) != 0;
                axi_resp.ar_ready = !slv_rand || $urandom_range(0, 3) != 0;
                axi_resp.b_valid  = b_pend;
                axi_resp.b.id     = 4'(AID);
                axi_resp.b.resp   = 2'b00;
                if (rd_act && !r_vld) r_vld = !slv_rand || $urandom_range(0, 3) != 0;
                wa = (rd_addr >> 3) + 64'(rd_beat);
                axi_resp.r_valid  = r_vld;
                axi_resp.r.id     = 4'(AID);
                axi_resp.r.resp   = 2'b00;
                axi_resp.r.data   = mem_slv.exists(wa) ? mem_slv[wa] : 64'd0;
                axi_resp.r.last   = rd_act && (rd_beat == rd_len);
            end
        end
    end

    int aw_hi;
    bit done_awv;

    task automatic do_cmd(input bit wr, input logic [63:0] addr, input int len, input bit rnd,
                          input int stall_at, input int rst_at,
                          output bit got_done, output bit got_err, output int lat);
        int  wb, stall_left;
        bit  w_hs, stalled, have_hold;
        logic [63:0] hold;
        wb = 0; stall_left = 0; w_hs = 0; stalled = 0; have_hold = 0; hold = '0;
        got_done = 0; got_err = 0; lat = 0; aw_hi = 0; done_awv = 0;
        rbuf.delete(); rlq.delete();
        exp_addr = addr; exp_len = 8'(len);
        @(negedge clk);
        cmd_valid_i   = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_len_i = 8'(len);
        wdata_valid_i = wr && (!rnd || $urandom_range(0, 3) != 0);
        wdata_i       = wbuf[0]; wstrb_i = sbuf[0];
        rdata_ready_i = 1'b0;
        #1;
        chk("cmd_ready", 64'(cmd_ready_o), 64'd1);
        for (int cyc = 1; cyc <= 2000 && !got_done; cyc++) begin
            @(negedge clk);
            cmd_valid_i = 1'b0;
            if (w_hs) begin wb++; wdata_valid_i = 1'b0; end
            if (wr && wb <= len && !wdata_valid_i) wdata_valid_i = !rnd || $urandom_range(0, 3) != 0;
            wdata_i = wbuf[wb]; wstrb_i = sbuf[wb];
            if (stall_at >= 0 && !stalled && rbuf.size() == stall_at) begin
                stalled = 1; stall_left = 5;
            end
            rdata_ready_i = (stall_left > 0) ? 1'b0 : (!rnd || $urandom_range(0, 3) != 0);
            if (rst_at >= 0 && wb == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid,
                    axi_req.r_ready, wdata_ready_o, rdata_valid_o, done_o, err_o}), 64'd0);
                chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
                wdata_valid_i = 1'b0; rdata_ready_i = 1'b0;
                return;
            end
            #1;
            if (axi_req.aw_valid) aw_hi++;
            if (done_o) begin got_done = 1; got_err = err_o; lat = cyc; done_awv = axi_req.aw_valid; end
            w_hs = wdata_valid_i && wdata_ready_o;
            if (rdata_valid_o && rdata_ready_i) begin
                rbuf.push_back(rdata_o);
                rlq.push_back(rdata_last_o);
            end
            if (stall_left > 0) begin
                chk("bp_rready", 64'(axi_req.r_ready), 64'd0);
                if (rdata_valid_o) begin
                    if (!have_hold) begin hold = rdata_o; have_hold = 1; end
                    else chk("bp_hold", rdata_o, hold);
                end
                stall_left--;
            end
        end
        wdata_valid_i = 1'b0; rdata_ready_i = 1'b0;
        if (!got_done) chk("done_seen", 64'd0, 64'd1);
    endtask

    task automatic cmp_read(input logic [63:0] addr, input int len);
        chk("rd_beats", 64'(rbuf.size()), 64'(len + 1));
        for (int i = 0; i <= len && i < rbuf.size(); i++) begin
            chk("rd_data", rbuf[i], ref_rd((addr >> 3) + 64'(i)));
            chk("rd_last", 64'(rlq[i]), 64'(i == len));
        end
    endtask

    bit  d, e;
    int  l, seen, v0, len, sel;
    bit  wr, exp_err;
    logic [63:0] addr;

    initial begin
        rst_n = 1'b0;
        cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = '0; cmd_len_i = '0;
        wdata_valid_i = 0; wdata_i = '0; wstrb_i = '0; rdata_ready_i = 0;
        exp_addr = '0; exp_len = '0;
        for (int i = 0; i < 257; i++) begin wbuf[i] = '0; sbuf[i] = 8'hFF; end
        repeat (3) @(negedge clk);
        #1;
        chk("reset_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid,
            axi_req.r_ready, wdata_ready_o, rdata_valid_o, done_o, err_o}), 64'd0);
        chk("reset_cmd_ready", 64'(cmd_ready_o), 64'd1);
        @(negedge clk); rst_n = 1'b1;

        // reset during beat 2 of a len=3 write
        slv_rand = 0;
        for (int i = 0; i < 4; i++) wbuf[i] = 64'hA0 + 64'(i);
        do_cmd(1, 64'h40, 3, 1'b1, -1, 2, d, e, l);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin @(negedge clk); #1; if (done_o) seen++; end
        chk("no_done_after_rst", 64'(seen), 64'd0);
        chk("idle_after_rst", 64'(cmd_ready_o), 64'd1);

        // write then read back len=3 at 0x80
        slv_rand = 1;
        for (int i = 0; i < 4; i++) begin wbuf[i] = 64'h11 * 64'(i + 1); sbuf[i] = 8'hFF; end
        do_cmd(1, 64'h80, 3, 1'b1, -1, -1, d, e, l);
        chk("wr80_done", 64'({d, e}), 64'b10);
        ref_wr(64'h80, 3);
        do_cmd(0, 64'h80, 3, 1'b1, -1, -1, d, e, l);
        chk("rd80_done", 64'({d, e}), 64'b10);
        cmp_read(64'h80, 3);
        for (int i = 0; i < 4 && i < rbuf.size(); i++) chk("rd80_const", rbuf[i], 64'h11 * 64'(i + 1));

        // partial strobe merge at 0x100
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'hFF;
        do_cmd(1, 64'h100, 0, 1'b1, -1, -1, d, e, l);
        ref_wr(64'h100, 0);
        wbuf[0] = 64'h0; sbuf[0] = 8'h0F;
        do_cmd(1, 64'h100, 0, 1'b1, -1, -1, d, e, l);
        ref_wr(64'h100, 0);
        sbuf[0] = 8'hFF;
        do_cmd(0, 64'h100, 0, 1'b1, -1, -1, d, e, l);
        chk("strb_data", rbuf.size() > 0 ? rbuf[0] : 64'hX, 64'hFFFF_FFFF_0000_0000);

        // rejected commands never touch the bus
        v0 = vld_seen;
        do_cmd(1, 64'h84, 0, 1'b0, -1, -1, d, e, l);
        chk("misalign_err", 64'({d, e}), 64'b11);
        do_cmd(0, 64'hFF8, 1, 1'b0, -1, -1, d, e, l);
        chk("cross_err", 64'({d, e}), 64'b11);
        @(negedge clk);
        chk("err_no_axi", 64'(vld_seen - v0), 64'd0);

        // zero-wait single-beat write latency
        slv_rand = 0;
        wbuf[0] = {$urandom, $urandom};
        do_cmd(1, 64'h200, 0, 1'b0, -1, -1, d, e, l);
        chk("lat_len0", 64'(l), 64'd5);
        ref_wr(64'h200, 0);

        // read backpressure mid-burst
        slv_rand = 1;
        for (int i = 0; i < 8; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
        do_cmd(1, 64'h300, 7, 1'b1, -1, -1, d, e, l);
        ref_wr(64'h300, 7);
        slv_rand = 0;
        do_cmd(0, 64'h300, 7, 1'b0, 3, -1, d, e, l);
        chk("bp_done", 64'({d, e}), 64'b10);
        cmp_read(64'h300, 7);

        // randomized command stream
        slv_rand = 1;
        for (int n = 0; n < 30; n++) begin
            wr  = $urandom_range(0, 1) == 1;
            len = $urandom_range(0, 15);
            sel = $urandom_range(0, 7);
            if (sel == 0)      addr = 64'h2000 + 64'($urandom_range(0, 4095));
            else if (sel == 1) addr = 64'h2FF8 - 64'(8 * $urandom_range(0, 3));
            else               addr = 64'h2000 + 64'(8 * $urandom_range(0, 511));
            exp_err = (addr % 8 != 0) || (int'(addr % 4096) + (len + 1) * 8 > 4096);
            for (int i = 0; i <= len; i++) begin
                wbuf[i] = {$urandom, $urandom};
                sbuf[i] = 8'($urandom);
            end
            do_cmd(wr, addr, len, 1'b1, -1, -1, d, e, l);
            chk("rnd_done", 64'({d, e}), 64'({1'b1, exp_err}));
            if (!exp_err && wr) ref_wr(addr, len);
            if (!exp_err && !wr) cmp_read(addr, len);
        end

        // stalled address phase times out
        aw_block = 1; slv_rand = 0;
        do_cmd(1, 64'h400, 0, 1'b0, -1, -1, d, e, l);
        chk("tmo_done", 64'({d, e}), 64'b11);
        chk("tmo_aw_cycles", 64'(aw_hi), 64'(TMO));
        chk("tmo_aw_low", 64'(done_awv), 64'd0);
        @(negedge clk); #1;
        chk("tmo_aw_low_after", 64'(axi_req.aw_valid), 64'd0);
        rst_n = 1'b0; aw_block = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // recovery after reset
        slv_rand = 1;
        for (int i = 0; i < 2; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
        do_cmd(1, 64'h500, 1, 1'b1, -1, -1, d, e, l);
        ref_wr(64'h500, 1);
        do_cmd(0, 64'h500, 1, 1'b1, -1, -1, d, e, l);
        chk("recover_done", 64'({d, e}), 64'b10);
        cmp_read(64'h500, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/fv_axi_mem_initiator.md
Name: fv_axi_mem_initiator

Overview:
- AXI4 initiator (master) that drives the FV AXI memory model from a simple command/stream interface.
- Role is the opposite end of the memory's responder port: image preload, readback and directed traffic in formal and sim harnesses, without a core.
- One outstanding transaction; INCR bursts of 64-bit beats on the ariane_axi request/response structs.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles waiting on any AXI handshake before aborting with error; 0 disables.
- AXI_ID, 0: ID driven on AW/AR and expected on B/R.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high only in IDLE.
- cmd_write_i  in  1  1=write, 0=read.
- cmd_addr_i  in  64  start byte address.
- cmd_len_i  in  8  beats minus one (AXI len).
- wdata_valid_i  in  1  write beat valid.
- wdata_ready_o  out  1  write beat accepted.
- wdata_i  in  64  write beat data.
- wstrb_i  in  8  write byte strobes.
- rdata_valid_o  out  1  read beat valid.
- rdata_ready_i  in  1  read beat consumed.
- rdata_o  out  64  read beat data.
- rdata_last_o  out  1  final read beat.
- done_o  out  1  one-cycle pulse at command completion.
- err_o  out  1  valid with done_o; 1 = command failed.
- axi_req_o  out  ariane_axi::req_t  AXI request channels.
- axi_resp_i  in  ariane_axi::resp_t  AXI response channels.

Behaviour:
- Reset (async, rst_ni low): state IDLE. All AXI valids and bready/rready low; cmd_ready_o=1; wdata_ready_o, rdata_valid_o, done_o, err_o = 0; beat counter, error flag and timeout counter cleared. Reset mid-transaction abandons it immediately; no completion pulse is produced.
- States: IDLE, CHECK, AW, W, B, AR, R, DONE.
- IDLE: on cmd_valid_i && cmd_ready_o, register write flag, address and len; go to CHECK.
- CHECK (1 cycle):
  - Error if addr[2:0] != 0.
  - Error if addr[11:0] + (len+1)*8 > 4096 (4 KB crossing, 13-bit arithmetic).
  - On error go to DONE with error flag set and no AXI activity. Otherwise go to AW (write) or AR (read).
- AW/AR: drive valid with addr, len, size=3, burst=INCR, id=AXI_ID; other fields zero (cache=0, prot=0, lock=0). Hold all fields stable until ready. On handshake go to W or R.
- W:
  - wdata_ready_o = axi_resp_i.w_ready combinationally; w_valid = wdata_valid_i; data and strb pass through.
  - wlast=1 when beat counter == len.
  - Counter increments on each W handshake. After the last beat go to B.
  - W is never issued before the AW handshake.
- B: bready=1. On b_valid, set error if bresp != OKAY or bid != AXI_ID; go to DONE.
- R:
  - rready = rdata_ready_i; rdata_valid_o = r_valid; data and last pass through.
  - Per beat, set error if rresp != OKAY or rid != AXI_ID.
  - Set error if rlast disagrees with counter == len (early or missing last); stop counting at len.
  - Go to DONE on the handshake carrying rlast.
- DONE (1 cycle): done_o=1, err_o=error flag; clear flag; go to IDLE.
- Timeout:
  - Counter resets on every handshake and on each state entry; increments while waiting in AW, W, B, AR or R.
  - Reaching TIMEOUT_CYCLES drops all valids/readies, sets error and goes to DONE.
  - After a timeout the memory side is undefined; the harness must reset.
- Throughput: back-to-back commands have at least 2 idle cycles between them (CHECK, DONE).
- Latency: write len=0 with zero-wait memory completes with done_o 5 cycles after command accept.

Test Plan:
- Reset mid-W: assert rst_ni=0 during beat 2 of a len=3 write -> all valids low at once, cmd_ready_o=1 after release, no done_o.
- Write len=3 at 0x80 (data 0x11..0x44, strb 0xFF), then read len=3 at 0x80 -> beats 0x11,0x22,0x33,0x44; rdata_last_o only on beat 4; done_o with err_o=0 twice.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF at 0x100 strb 0xFF, then 0x0 strb 0x0F; read back -> 0xFFFF_FFFF_0000_0000.
- Misaligned addr 0x84 or crossing burst (addr 0xFF8, len=1) -> done_o with err_o=1, no AW/AR valid ever asserted.
- Backpressure: rdata_ready_i low for 5 cycles mid-burst -> rdata_o held stable, no beat lost or duplicated, rready low throughout.
- Timeout: TIMEOUT_CYCLES=16, memory holds aw_ready=0 -> done_o,err_o=1 at cycle 16 of AW wait, aw_valid low afterwards.
